// File: rtl/fetch_pc_gen_pkg.sv
// Shared definitions for the instruction-fetch PC generator: fetch-group
// defaults, the FSM state set and the per-slot valid-mask helper.
package if_pkg;

   // Default number of instructions fetched per group (legal: 1, 2, 4)
   localparam int FETCH_W_DEFAULT = 2;

   // Default first fetch address after reset
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

   // Fetch FSM states
   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      RUN     = 2'd1,
      HOLD    = 2'd2,
      HOLD_RD = 2'd3
   } fetch_state_e;

   // Valid mask for a group entered at pc: slots from pc's slot up to the
   // last slot of the group are live, earlier slots are skipped. Returned
   // at the maximum group width; callers keep the low fetch_w bits.
   function automatic logic [3:0] slot_mask(input logic [31:0] pc, input int fetch_w);
      logic [31:0] word_idx;
      int          slot;
      logic [3:0]  mask;
      word_idx = pc >> 2;
      slot     = (fetch_w > 1) ? int'(word_idx & 32'(fetch_w - 1)) : 0;
      mask     = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         mask[i] = (i < fetch_w) && (i >= slot);
      end
      return mask;
   endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Bundle of the fetch PC generator's request and result signals.
// master: the PC generator itself; slave: the surrounding pipeline.
interface fetch_pc_gen_if
   import if_pkg::*;
#(
   parameter int FETCH_W = FETCH_W_DEFAULT
) ();

   logic [31:0]        pc_predict;
   logic               pred_valid;
   logic [31:0]        pc_BR;
   logic               EX_BR;
   logic [31:0]        pc_ID;
   logic               ID_BR;
   logic               stall_ICache;
   logic               stall_full_instr;
   logic [31:0]        pc_IF1;
   logic               is_valid;
   logic [FETCH_W-1:0] valid_mask;
   logic               exc_adef;

   modport master (
      input  pc_predict, pred_valid,
      input  pc_BR, EX_BR,
      input  pc_ID, ID_BR,
      input  stall_ICache, stall_full_instr,
      output pc_IF1, is_valid, valid_mask, exc_adef
   );

   modport slave (
      output pc_predict, pred_valid,
      output pc_BR, EX_BR,
      output pc_ID, ID_BR,
      output stall_ICache, stall_full_instr,
      input  pc_IF1, is_valid, valid_mask, exc_adef
   );

endinterface

// File: rtl/fetch_pc_gen_redirect_buf.sv
// One-entry store for a redirect (EX or ID) that arrives while fetch is
// held. An EX redirect always wins the entry; an ID redirect may only
// replace an older ID redirect. The entry is dropped on the first cycle
// fetch is allowed to move, since that cycle uses it (or something newer).
module pc_redirect_buf (
   input  logic        clk,
   input  logic        rstn,
   input  logic        hold,
   input  logic        ex_br,
   input  logic [31:0] pc_br,
   input  logic        id_br,
   input  logic [31:0] pc_id,
   output logic        pend_valid,
   output logic [31:0] pend_pc
);

   logic pend_is_ex;

   // Capture redirects while held, keep the older EX over a newer ID, drop on release
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pend_valid <= 1'b0;
         pend_is_ex <= 1'b0;
         pend_pc    <= 32'h0;
      end else if (hold) begin
         if (ex_br) begin
            pend_valid <= 1'b1;
            pend_is_ex <= 1'b1;
            pend_pc    <= pc_br;
         end else if (id_br && !(pend_valid && pend_is_ex)) begin
            pend_valid <= 1'b1;
            pend_is_ex <= 1'b0;
            pend_pc    <= pc_id;
         end
      end else begin
         pend_valid <= 1'b0;
         pend_is_ex <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_pc_gen.sv
// Instruction-fetch PC generator. Each cycle fetch is not stalled it
// emits the next fetch-group PC chosen from EX redirect, a redirect held
// over from a stall, ID redirect, the predictor, or the next sequential
// group, together with a per-slot valid mask.
// Optional feature macro FETCH_PC_ADEF_CHECK_EN: when defined, misaligned
// targets are emitted as-is and flagged with exc_adef; otherwise the low
// two address bits are cleared and exc_adef is always 0.
module fetch_pc_gen
   import if_pkg::*;
#(
   parameter int          FETCH_W  = FETCH_W_DEFAULT,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic           clk,
   input  logic           rstn,
   fetch_pc_gen_if.master bus
);

   localparam logic [1:0]  ST_BOOT     = BOOT;
   localparam logic [1:0]  ST_RUN      = RUN;
   localparam logic [1:0]  ST_HOLD     = HOLD;
   localparam logic [1:0]  ST_HOLD_RD  = HOLD_RD;
   localparam logic [31:0] GROUP_BYTES = 32'(4 * FETCH_W);

   logic               stall;
   logic [1:0]         state;
   logic [1:0]         state_n;
   logic [31:0]        pc_n;
   logic               valid_n;
   logic [FETCH_W-1:0] mask_n;
   logic               exc_n;
   logic [31:0]        target;
   logic [31:0]        seq_pc;
   logic [3:0]         full_mask;
   logic               pend_valid;
   logic [31:0]        pend_pc;

   assign stall  = bus.stall_ICache | bus.stall_full_instr;
   assign seq_pc = (bus.pc_IF1 & ~(GROUP_BYTES - 32'd1)) + GROUP_BYTES;

   pc_redirect_buf u_redirect_buf (
      .clk        (clk),
      .rstn       (rstn),
      .hold       (stall),
      .ex_br      (bus.EX_BR),
      .pc_br      (bus.pc_BR),
      .id_br      (bus.ID_BR),
      .pc_id      (bus.pc_ID),
      .pend_valid (pend_valid),
      .pend_pc    (pend_pc)
   );

   // Pick the next fetch target by redirect priority; BOOT stands in for the predictor/sequential path with RESET_PC
   always_comb begin
      target = seq_pc;
      if (bus.EX_BR) begin
         target = bus.pc_BR;
      end else if (pend_valid) begin
         target = pend_pc;
      end else if (bus.ID_BR) begin
         target = bus.pc_ID;
      end else if (state == ST_BOOT) begin
         target = RESET_PC;
      end else if (bus.pred_valid) begin
         target = bus.pc_predict;
      end
   end

   // Next-state and next-output decode. A stall in BOOT without a redirect stays in BOOT so the RESET_PC group is still emitted later
   always_comb begin
      state_n   = state;
      pc_n      = bus.pc_IF1;
      valid_n   = 1'b0;
      mask_n    = '0;
      exc_n     = 1'b0;
      full_mask = 4'b0000;
      if (stall) begin
         if (pend_valid || bus.EX_BR || bus.ID_BR) begin
            state_n = ST_HOLD_RD;
         end else if (state == ST_BOOT) begin
            state_n = ST_BOOT;
         end else begin
            state_n = ST_HOLD;
         end
      end else begin
         state_n = ST_RUN;
         valid_n = 1'b1;
`ifdef FETCH_PC_ADEF_CHECK_EN
         pc_n = target;
         if (target[1:0] != 2'b00) begin
            exc_n = 1'b1;
         end else begin
            full_mask = slot_mask(target, FETCH_W);
            mask_n    = full_mask[FETCH_W-1:0];
         end
`else
         pc_n      = target & ~32'h3;
         full_mask = slot_mask(pc_n, FETCH_W);
         mask_n    = full_mask[FETCH_W-1:0];
`endif
      end
   end

   // Register the FSM state and all fetch outputs
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state          <= ST_BOOT;
         bus.pc_IF1     <= RESET_PC;
         bus.is_valid   <= 1'b0;
         bus.valid_mask <= '0;
         bus.exc_adef   <= 1'b0;
      end else begin
         state          <= state_n;
         bus.pc_IF1     <= pc_n;
         bus.is_valid   <= valid_n;
         bus.valid_mask <= mask_n;
         bus.exc_adef   <= exc_n;
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen (FETCH_W=2, RESET_PC=1c000000).
// A behavioural model tracks the expected outputs; a negedge process
// compares every output each cycle, and directed steps add literal checks.
module tb_fetch_pc_gen;
   import if_pkg::*;

   localparam int          FETCH_W  = 2;
   localparam logic [31:0] RESET_PC = 32'h1c000000;
   localparam logic [31:0] G        = 32'(4 * FETCH_W);

   logic clk;
   logic rstn;
   int   n_checks;
   int   n_fail;
   logic check_en;

   fetch_pc_gen_if #(.FETCH_W(FETCH_W)) bus ();

   fetch_pc_gen #(.FETCH_W(FETCH_W), .RESET_PC(RESET_PC)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // Clock generation
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model state: expected outputs, whether the reset group has been emitted, pending redirect
   logic [31:0]        exp_pc;
   logic               exp_valid;
   logic [FETCH_W-1:0] exp_mask;
   logic               exp_exc;
   logic               m_booted;
   logic               m_pend;
   logic               m_pend_ex;
   logic [31:0]        m_pend_pc;
   logic [31:0]        m_tgt;

   // Behavioural model evaluated from the inputs present at each rising edge
   always @(posedge clk) begin
      if (!rstn) begin
         exp_pc = RESET_PC; exp_valid = 0; exp_mask = '0; exp_exc = 0;
         m_booted = 0; m_pend = 0; m_pend_ex = 0; m_pend_pc = 0;
      end else if (bus.stall_ICache || bus.stall_full_instr) begin
         exp_valid = 0; exp_mask = '0; exp_exc = 0;
         if (bus.EX_BR) begin
            m_pend = 1; m_pend_ex = 1; m_pend_pc = bus.pc_BR;
         end else if (bus.ID_BR && !(m_pend && m_pend_ex)) begin
            m_pend = 1; m_pend_ex = 0; m_pend_pc = bus.pc_ID;
         end
      end else begin
         if (bus.EX_BR)           m_tgt = bus.pc_BR;
         else if (m_pend)         m_tgt = m_pend_pc;
         else if (bus.ID_BR)      m_tgt = bus.pc_ID;
         else if (!m_booted)      m_tgt = RESET_PC;
         else if (bus.pred_valid) m_tgt = bus.pc_predict;
         else                     m_tgt = exp_pc - (exp_pc % G) + G;
         m_pend = 0; m_pend_ex = 0; m_booted = 1;
         exp_valid = 1; exp_exc = 0;
`ifdef FETCH_PC_ADEF_CHECK_EN
         exp_pc = m_tgt;
         if (m_tgt % 4 != 0) exp_exc = 1;
`else
         exp_pc = m_tgt - (m_tgt % 4);
`endif
         for (int i = 0; i < FETCH_W; i++)
            exp_mask[i] = !exp_exc && (i >= int'((exp_pc / 4) % FETCH_W));
      end
   end

   // Compare one value, count it, report a failure
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison of DUT against the model
   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("model pc_IF1", bus.pc_IF1, exp_pc);
         checkOutput("model is_valid", 32'(bus.is_valid), 32'(exp_valid));
         checkOutput("model valid_mask", 32'(bus.valid_mask), 32'(exp_mask));
         checkOutput("model exc_adef", 32'(bus.exc_adef), 32'(exp_exc));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs; st = {stall_full_instr, stall_ICache}
   task automatic applyStimulus(input logic [1:0] st, input logic ex, input logic [31:0] pbr,
                                input logic id, input logic [31:0] pid,
                                input logic pv, input logic [31:0] ppred);
      bus.stall_ICache     = st[0];
      bus.stall_full_instr = st[1];
      bus.EX_BR = ex; bus.pc_BR = pbr;
      bus.ID_BR = id; bus.pc_ID = pid;
      bus.pred_valid = pv; bus.pc_predict = ppred;
      tick();
   endtask

   task automatic idle();
      applyStimulus(2'b00, 0, 32'h0, 0, 32'h0, 0, 32'h0);
   endtask

   task automatic checkGroup(input string name, input logic [31:0] pc, input logic v, input logic [1:0] m);
      checkOutput({name, " pc"}, bus.pc_IF1, pc);
      checkOutput({name, " valid"}, 32'(bus.is_valid), 32'(v));
      checkOutput({name, " mask"}, 32'(bus.valid_mask), 32'(m));
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   // Directed sequence followed by a random phase
   initial begin
      n_checks = 0; n_fail = 0; check_en = 0;
      rstn = 0;
      bus.stall_ICache = 0; bus.stall_full_instr = 0;
      bus.EX_BR = 0; bus.pc_BR = 0; bus.ID_BR = 0; bus.pc_ID = 0;
      bus.pred_valid = 0; bus.pc_predict = 0;
      tick();
      check_en = 1;
      tick();
      checkGroup("reset", RESET_PC, 0, 2'b00);
      checkOutput("reset exc", 32'(bus.exc_adef), 32'h0);

      rstn = 1;
      idle();  checkGroup("boot", 32'h1c000000, 1, 2'b11);
      idle();  checkGroup("seq1", 32'h1c000008, 1, 2'b11);
      idle();  checkGroup("seq2", 32'h1c000010, 1, 2'b11);

      applyStimulus(2'b00, 0, 0, 0, 0, 1, 32'h1c000104);
      checkGroup("predict", 32'h1c000104, 1, 2'b10);
      idle();  checkGroup("after predict", 32'h1c000108, 1, 2'b11);

      applyStimulus(2'b01, 0, 0, 0, 0, 0, 0);
      checkGroup("stall1", 32'h1c000108, 0, 2'b00);
      applyStimulus(2'b10, 1, 32'h1c000200, 0, 0, 0, 0);
      checkGroup("stall2", 32'h1c000108, 0, 2'b00);
      applyStimulus(2'b11, 0, 0, 0, 0, 0, 0);
      checkGroup("stall3", 32'h1c000108, 0, 2'b00);
      idle();  checkGroup("pending EX", 32'h1c000200, 1, 2'b11);

      applyStimulus(2'b00, 1, 32'h1c000300, 1, 32'h1c000400, 1, 32'h1c000500);
      checkGroup("priority", 32'h1c000300, 1, 2'b11);

      applyStimulus(2'b00, 1, 32'hfffffff8, 0, 0, 0, 0);
      checkGroup("pre-wrap", 32'hfffffff8, 1, 2'b11);
      idle();  checkGroup("wrap", 32'h00000000, 1, 2'b11);

      applyStimulus(2'b01, 0, 0, 1, 32'h1c000600, 0, 0);
      applyStimulus(2'b01, 1, 32'h1c000700, 0, 0, 0, 0);
      applyStimulus(2'b01, 0, 0, 1, 32'h1c000800, 0, 0);
      idle();  checkGroup("EX keeps entry", 32'h1c000700, 1, 2'b11);

      applyStimulus(2'b01, 0, 0, 1, 32'h1c000900, 0, 0);
      applyStimulus(2'b01, 0, 0, 1, 32'h1c000a04, 0, 0);
      idle();  checkGroup("ID replaces ID", 32'h1c000a04, 1, 2'b10);

      applyStimulus(2'b01, 0, 0, 1, 32'h1c000b00, 0, 0);
      applyStimulus(2'b00, 1, 32'h1c000c00, 0, 0, 0, 0);
      checkGroup("EX over pending", 32'h1c000c00, 1, 2'b11);
      idle();  checkGroup("pending cleared", 32'h1c000c08, 1, 2'b11);

      applyStimulus(2'b01, 1, 32'h1c000d00, 0, 0, 0, 0);
      rstn = 0;
      idle();  checkGroup("mid-pending reset", RESET_PC, 0, 2'b00);
      rstn = 1;
      idle();  checkGroup("pending discarded", 32'h1c000000, 1, 2'b11);

      rstn = 0; idle(); rstn = 1;
      applyStimulus(2'b00, 1, 32'h1c000e00, 0, 0, 0, 0);
      checkGroup("boot redirect", 32'h1c000e00, 1, 2'b11);

      rstn = 0; idle(); rstn = 1;
      applyStimulus(2'b01, 0, 0, 1, 32'h1c000f00, 0, 0);
      applyStimulus(2'b01, 0, 0, 0, 0, 0, 0);
      checkGroup("boot stall", RESET_PC, 0, 2'b00);
      idle();  checkGroup("boot pending", 32'h1c000f00, 1, 2'b11);

      applyStimulus(2'b00, 1, 32'h1c000002, 0, 0, 0, 0);
`ifdef FETCH_PC_ADEF_CHECK_EN
      checkGroup("misaligned", 32'h1c000002, 1, 2'b00);
      checkOutput("misaligned exc", 32'(bus.exc_adef), 32'h1);
`else
      checkGroup("misaligned", 32'h1c000000, 1, 2'b11);
      checkOutput("misaligned exc", 32'(bus.exc_adef), 32'h0);
`endif
      idle();  checkGroup("after misaligned", 32'h1c000008, 1, 2'b11);
      checkOutput("after misaligned exc", 32'(bus.exc_adef), 32'h0);

      for (int i = 0; i < 300; i++) begin
         applyStimulus(2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0),
                       $urandom_range(0, 7) == 0, $urandom,
                       $urandom_range(0, 5) == 0, $urandom,
                       $urandom_range(0, 3) == 0, $urandom);
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
